// File: rtl/iic_slave_mem.sv
// iic_slave_mem: I2C responder that behaves like a 24LC64-style EEPROM backed by a small register file.
// scl/sda are synchronized and edge-detected on clk; sda is only ever pulled low or released.
module iic_slave_mem #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000,
  parameter int         MEM_AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  output logic              busy,
  output logic              wr_en,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_WR_HI,
    S_WR_LO,
    S_WR_DATA,
    S_RD_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_d;
  logic              mem_we;
  logic [7:0]        mem [2**MEM_AW];

  // [0],[1] form the synchronizer, [2] is the delay stage used for edge detection
  logic [2:0] scl_sh, sda_sh;
  logic       scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0] rx_byte, rd_byte;
  logic       receiving;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      scl_sh <= {scl_sh[1:0], scl};
      sda_sh <= {sda_sh[1:0], sda};
    end
  end

  assign scl_rise  = scl_sh[1] & ~scl_sh[2];
  assign scl_fall  = ~scl_sh[1] & scl_sh[2];
  assign bus_start = scl_sh[1] & scl_sh[2] & ~sda_sh[1] & sda_sh[2];
  assign bus_stop  = scl_sh[1] & scl_sh[2] & sda_sh[1] & ~sda_sh[2];

  assign rx_byte   = {shift_q, sda_sh[1]};
  assign rd_byte   = mem[ptr_q];
  assign receiving = (state_q == S_DEV_ADDR) || (state_q == S_WR_HI) ||
                     (state_q == S_WR_LO) || (state_q == S_WR_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // bit_cnt counts scl rising edges within a 9-clock frame; 8 means the ack slot is next.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy;
    mem_we    = 1'b0;
    if (bus_stop) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (bus_start) begin
      state_d   = S_DEV_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (state_q == S_IDLE) begin
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      if (bit_cnt_q != 4'd8) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (receiving) begin
          shift_d = rx_byte[6:0];
          if (bit_cnt_q == 4'd7) begin
            case (state_q)
              S_DEV_ADDR: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                end else begin
                  state_d   = S_IDLE;
                  bit_cnt_d = 4'd0;
                  busy_d    = 1'b0;
                end
              end
              S_WR_LO:   ptr_d = rx_byte[MEM_AW-1:0];
              S_WR_DATA: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
              end
              default: ;
            endcase
          end
        end
      end else begin
        bit_cnt_d = 4'd0;
        case (state_q)
          S_DEV_ADDR: state_d = shift_q[0] ? S_RD_DATA : S_WR_HI;
          S_WR_HI:    state_d = S_WR_LO;
          S_WR_LO:    state_d = S_WR_DATA;
          S_RD_DATA: begin
            // pointer advances once per byte sent, whether the master acks or not
            ptr_d = ptr_q + 1'b1;
            if (sda_sh[1]) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end else if (scl_fall) begin
      if (state_q == S_RD_DATA)
        sda_oe_d = (bit_cnt_q != 4'd8) && !rd_byte[~bit_cnt_q[2:0]];
      else
        sda_oe_d = (bit_cnt_q == 4'd8);
    end
  end

  // wr_en is a one-clk strobe qualifying wr_addr/wr_data; there is no back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy      <= busy_d;
      wr_en     <= mem_we;
      if (mem_we) begin
        mem[ptr_q] <= rx_byte;
        wr_addr    <= ptr_q;
        wr_data    <= rx_byte;
      end
    end
  end

endmodule
